mmio_uart_tx: RTL

Memory-mapped UART transmitter responding on the CPU data-memory port (word address, byte enables, write enable, one-cycle registered read data), in parallel with the RAM. Software stores bytes into a TXDATA register. The bytes are buffered in a FIFO and shifted out as 8N1 serial frames at a programmable bit period. Read data is zero outside the block's window so the top level can OR it with RAM read data.

---
 rtl/mmio_uart_tx_pkg.sv | 21 ++
 rtl/mmio_uart_tx_if.sv | 12 +
 rtl/mmio_uart_tx_fifo.sv | 47 ++++
 rtl/mmio_uart_tx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and transmit FSM state encoding.
package mmio_uart_tx_pkg;
    localparam logic [1:0] UART_REG_TXDATA = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_DIV    = 2'd2;
    localparam logic [1:0] UART_REG_RSVD   = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory port as seen by the UART: word address, lanes, strobe and
// registered read data.
interface mmio_uart_tx_if;
    logic [29:0] address;
    logic [31:0] data;
    logic [3:0]  byteena;
    logic        wren;
    logic [31:0] q;

    modport master (output address, data, byteena, wren, input q);
    modport slave  (input address, data, byteena, wren, output q);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO with first-word fall-through on rdata; a push while full is
// accepted only when a pop happens on the same edge.
module tx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          wr_en, rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers in a
// 4-word window, buffered through tx_fifo, with a bit-period counter FSM.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [29:0] BASE_WADDR = 30'h0002_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic           clk,
    input  logic           reset_n,
    mmio_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           tx_idle
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          hit, wr_hit, push, pop, full, empty, ovf, ovf_set, ovf_clr;
    logic [1:0]    off;
    logic [7:0]    rdata;
    logic [CW-1:0] count;
    logic [31:0]   count_ext, status, rd_mux;
    logic [15:0]   divisor;
    logic          unused_bits;

    tx_state_e   state, state_n;
    logic [7:0]  shift, shift_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [15:0] tick, tick_n, div_lat, div_n;

    assign hit         = (bus.address[29:2] == BASE_WADDR[29:2]);
    assign off         = bus.address[1:0];
    assign wr_hit      = bus.wren & hit;
    assign push        = wr_hit & (off == UART_REG_TXDATA) & bus.byteena[0];
    assign ovf_clr     = wr_hit & (off == UART_REG_STATUS) & bus.byteena[0] & bus.data[3];
    assign ovf_set     = push & full & ~pop;
    assign unused_bits = ^{bus.data[31:16], bus.byteena[3:2]};

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .wdata(bus.data[7:0]),
        .rdata(rdata), .full(full), .empty(empty), .count(count)
    );

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        tick_n  = tick;
        div_n   = div_lat;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                shift_n = rdata;
                div_n   = divisor;
                tick_n  = '0;
                bit_n   = '0;
                state_n = S_START;
            end
            S_START: begin
                tx     = 1'b0;
                tick_n = tick + 16'd1;
                if (tick == div_lat) begin
                    tick_n  = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx     = shift[0];
                tick_n = tick + 16'd1;
                if (tick == div_lat) begin
                    tick_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_cnt == 3'd7) state_n = S_STOP;
                    else                 bit_n   = bit_cnt + 3'd1;
                end
            end
            S_STOP: begin
                tick_n = tick + 16'd1;
                if (tick == div_lat) begin
                    tick_n  = '0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tick    <= '0;
            div_lat <= '0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_n;
            tick    <= tick_n;
            div_lat <= div_n;
        end
    end

    assign tx_idle = empty & (state == S_IDLE);

    // A set on the same edge as a clear wins, so a lost byte is never hidden.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf     <= 1'b0;
            divisor <= DIV_RESET;
        end else begin
            ovf <= ovf_set | (ovf & ~ovf_clr);
            if (wr_hit && off == UART_REG_DIV) begin
                if (bus.byteena[1]) divisor[15:8] <= bus.data[15:8];
                if (bus.byteena[0]) divisor[7:0]  <= bus.data[7:0];
            end
        end
    end

    always_comb begin
        count_ext = 32'(count);
        status                       = '0;
        status[ST_FULL]              = full;
        status[ST_EMPTY]             = empty;
        status[ST_BUSY]              = (state != S_IDLE);
        status[ST_OVF]               = ovf;
        status[ST_CNT_LSB +: 4]      = count_ext[3:0];
        rd_mux = '0;
        if (hit) begin
            case (off)
                UART_REG_STATUS: rd_mux = status;
                UART_REG_DIV:    rd_mux = {16'h0, divisor};
                default:         rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) bus.q <= '0;
        else          bus.q <= rd_mux;
    end
endmodule
